// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic array sequencer.
package systolic_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_ROW   = 3;
    localparam int DEF_COL   = 3;
    localparam int DEF_VEC_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Cycles from a feature handshake to its result at the array's bottom edge.
    function automatic int lat(input int row, input int col);
        return row + col;
    endfunction

endpackage

// File: rtl/skew_line.sv
// Resettable DEPTH-stage delay line for one feature lane of the systolic array.
module skew_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] lane_d,
    output logic [WIDTH-1:0] lane_q
);

    logic [WIDTH-1:0] stage_r [DEPTH];

    // Shift one stage per cycle; stage 0 takes the newly pushed lane value.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= '0;
            end
        end else begin
            stage_r[0] <= lane_d;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign lane_q = stage_r[DEPTH-1];

endmodule

// File: rtl/systolic_ctrl.sv
// Weight-stationary systolic array sequencer: weight load, skewed feature stream, drain.
// Optional perf counters are enabled by defining SYSTOLIC_CTRL_PERF_EN.
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ROW   = DEF_ROW,
    parameter int COL   = DEF_COL,
    parameter int VEC_W = DEF_VEC_W
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start_in,
    input  logic [VEC_W-1:0]     num_vecs_in,
    output logic                 busy_out,
    output logic                 done_out,
    input  logic                 w_valid_in,
    output logic                 w_ready_out,
    input  logic [ROW*WIDTH-1:0] w_data_in,
    input  logic                 f_valid_in,
    output logic                 f_ready_out,
    input  logic [ROW*WIDTH-1:0] f_data_in,
    output logic                 arr_ctrl_out,
    output logic [ROW*WIDTH-1:0] arr_weight_out,
    output logic [ROW*WIDTH-1:0] arr_feature_out,
    output logic                 res_valid_out
`ifdef SYSTOLIC_CTRL_PERF_EN
    ,
    output logic [31:0]          perf_busy_cyc_out,
    output logic [15:0]          perf_bubble_cyc_out
`endif
);

    localparam int LAT     = lat(ROW, COL);
    localparam int BEAT_W  = $clog2(COL) + 1;
    localparam int DRAIN_W = $clog2(LAT) + 1;
    localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(COL - 1);
    localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(LAT - 1);

    state_t               state_r;
    logic [VEC_W-1:0]     nv_r;
    logic [VEC_W-1:0]     vec_cnt_r;
    logic [BEAT_W-1:0]    beat_cnt_r;
    logic [DRAIN_W-1:0]   drain_cnt_r;
    logic [LAT-1:0]       vld_pipe_r;
    logic                 w_hs_s;
    logic                 f_hs_s;
    logic [VEC_W:0]       vec_next_s;
    logic [ROW*WIDTH-1:0] lane_in_s;

    assign w_hs_s     = w_valid_in & w_ready_out;
    assign f_hs_s     = f_valid_in & f_ready_out;
    assign vec_next_s = {1'b0, vec_cnt_r} + (VEC_W+1)'(1);

    // Tile sequencer; handshake readies are registered alongside the state they belong to.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r        <= IDLE;
            nv_r           <= '0;
            vec_cnt_r      <= '0;
            beat_cnt_r     <= '0;
            drain_cnt_r    <= '0;
            busy_out       <= 1'b0;
            done_out       <= 1'b0;
            w_ready_out    <= 1'b0;
            f_ready_out    <= 1'b0;
            arr_ctrl_out   <= 1'b0;
            arr_weight_out <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    arr_ctrl_out <= 1'b0;
                    if (start_in) begin
                        state_r     <= LOAD_W;
                        nv_r        <= num_vecs_in;
                        beat_cnt_r  <= '0;
                        busy_out    <= 1'b1;
                        w_ready_out <= 1'b1;
                    end
                end
                LOAD_W: begin
                    // Shift mode holds through stalls; only accepted beats move the weight register.
                    arr_ctrl_out <= 1'b1;
                    if (w_hs_s) begin
                        arr_weight_out <= w_data_in;
                        beat_cnt_r     <= beat_cnt_r + BEAT_W'(1);
                        if (beat_cnt_r == LAST_BEAT) begin
                            w_ready_out <= 1'b0;
                            if (nv_r == '0) begin
                                state_r     <= DRAIN;
                                drain_cnt_r <= '0;
                            end else begin
                                state_r     <= STREAM;
                                f_ready_out <= 1'b1;
                                vec_cnt_r   <= '0;
                            end
                        end
                    end
                end
                STREAM: begin
                    arr_ctrl_out <= 1'b0;
                    if (f_hs_s) begin
                        vec_cnt_r <= vec_next_s[VEC_W-1:0];
                        if (vec_next_s == {1'b0, nv_r}) begin
                            state_r     <= DRAIN;
                            f_ready_out <= 1'b0;
                            drain_cnt_r <= '0;
                        end
                    end
                end
                DRAIN: begin
                    arr_ctrl_out <= 1'b0;
                    drain_cnt_r  <= drain_cnt_r + DRAIN_W'(1);
                    if (drain_cnt_r == LAST_DRAIN) begin
                        state_r  <= DONE;
                        done_out <= 1'b1;
                    end
                end
                DONE: begin
                    state_r  <= IDLE;
                    done_out <= 1'b0;
                    busy_out <= 1'b0;
                end
                default: begin
                    state_r      <= IDLE;
                    busy_out     <= 1'b0;
                    done_out     <= 1'b0;
                    w_ready_out  <= 1'b0;
                    f_ready_out  <= 1'b0;
                    arr_ctrl_out <= 1'b0;
                end
            endcase
        end
    end

    // Bubbles and drain cycles push zeros so lanes stay correctly spaced.
    always_comb begin
        if (f_hs_s) begin
            lane_in_s = f_data_in;
        end else begin
            lane_in_s = '0;
        end
    end

    // Result-valid tracks each pushed vector through the full array latency.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            vld_pipe_r <= '0;
        end else begin
            vld_pipe_r <= {vld_pipe_r[LAT-2:0], f_hs_s};
        end
    end

    assign res_valid_out = vld_pipe_r[LAT-1];

    for (genvar r = 0; r < ROW; r++) begin : g_lane
        skew_line #(
            .DEPTH (r + 1),
            .WIDTH (WIDTH)
        ) u_skew (
            .clk_in (clk_in),
            .rst_in (rst_in),
            .lane_d (lane_in_s[r*WIDTH +: WIDTH]),
            .lane_q (arr_feature_out[r*WIDTH +: WIDTH])
        );
    end

`ifdef SYSTOLIC_CTRL_PERF_EN
    // Saturating activity counters, restarted by every accepted tile.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            perf_busy_cyc_out   <= 32'd0;
            perf_bubble_cyc_out <= 16'd0;
        end else if ((state_r == IDLE) && start_in) begin
            perf_busy_cyc_out   <= 32'd0;
            perf_bubble_cyc_out <= 16'd0;
        end else begin
            if (busy_out && (perf_busy_cyc_out != 32'hFFFF_FFFF)) begin
                perf_busy_cyc_out <= perf_busy_cyc_out + 32'd1;
            end
            if ((state_r == STREAM) && !f_hs_s && (perf_bubble_cyc_out != 16'hFFFF)) begin
                perf_bubble_cyc_out <= perf_bubble_cyc_out + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench for systolic_ctrl: directed tiles plus randomized tiles against a
// timestamp-based reference model (perf counters checked when SYSTOLIC_CTRL_PERF_EN is defined).
module tb_systolic_ctrl;

    localparam int W     = 8;
    localparam int ROW   = 3;
    localparam int COL   = 3;
    localparam int VEC_W = 8;
    localparam int LAT   = ROW + COL;
    localparam int DW    = ROW * W;
    localparam int HIST  = 4096;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic             start_in;
    logic [VEC_W-1:0] num_vecs_in;
    logic             busy_out;
    logic             done_out;
    logic             w_valid_in;
    logic             w_ready_out;
    logic [DW-1:0]    w_data_in;
    logic             f_valid_in;
    logic             f_ready_out;
    logic [DW-1:0]    f_data_in;
    logic             arr_ctrl_out;
    logic [DW-1:0]    arr_weight_out;
    logic [DW-1:0]    arr_feature_out;
    logic             res_valid_out;
`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0]      perf_busy_cyc_out;
    logic [15:0]      perf_bubble_cyc_out;
`endif

    systolic_ctrl #(.WIDTH(W), .ROW(ROW), .COL(COL), .VEC_W(VEC_W)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .start_in        (start_in),
        .num_vecs_in     (num_vecs_in),
        .busy_out        (busy_out),
        .done_out        (done_out),
        .w_valid_in      (w_valid_in),
        .w_ready_out     (w_ready_out),
        .w_data_in       (w_data_in),
        .f_valid_in      (f_valid_in),
        .f_ready_out     (f_ready_out),
        .f_data_in       (f_data_in),
        .arr_ctrl_out    (arr_ctrl_out),
        .arr_weight_out  (arr_weight_out),
        .arr_feature_out (arr_feature_out),
        .res_valid_out   (res_valid_out)
`ifdef SYSTOLIC_CTRL_PERF_EN
        ,
        .perf_busy_cyc_out   (perf_busy_cyc_out),
        .perf_bubble_cyc_out (perf_bubble_cyc_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    // Reference model: tile progress as counts plus a timestamped history of pushes.
    int          total;
    int          bad;
    int          cyc;
    bit          m_act;
    int          m_nv;
    int          m_beats;
    int          m_vecs;
    int          m_done_cyc;
    int          valid_from;
    int          m_busy;
    int          m_bub;
    bit          m_ctrl;
    logic [DW-1:0] m_w;
    bit          push_v [HIST];
    logic [DW-1:0] push_d [HIST];

    function automatic bit m_wr();
        return m_act && (m_beats < COL);
    endfunction

    function automatic bit m_fr();
        return m_act && (m_beats == COL) && (m_vecs < m_nv);
    endfunction

    function automatic bit pushed(input int idx);
        return (idx >= 0) && (idx >= valid_from) && (idx < HIST) && push_v[idx];
    endfunction

    // Lane r shows the vector pushed r+1 cycles earlier.
    function automatic logic [DW-1:0] exp_feat(input int c);
        logic [DW-1:0] f;
        f = '0;
        for (int r = 0; r < ROW; r++) begin
            if (pushed(c - 1 - r)) f[r*W +: W] = push_d[c - 1 - r][r*W +: W];
        end
        return f;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_outputs();
        chk("busy",      32'(busy_out),        32'(m_act));
        chk("done",      32'(done_out),        32'(m_act && (cyc == m_done_cyc)));
        chk("w_ready",   32'(w_ready_out),     32'(m_wr()));
        chk("f_ready",   32'(f_ready_out),     32'(m_fr()));
        chk("arr_ctrl",  32'(arr_ctrl_out),    32'(m_ctrl));
        chk("arr_weight",32'(arr_weight_out),  32'(m_w));
        chk("arr_feat",  32'(arr_feature_out), 32'(exp_feat(cyc)));
        chk("res_valid", 32'(res_valid_out),   32'(pushed(cyc - LAT)));
`ifdef SYSTOLIC_CTRL_PERF_EN
        chk("perf_busy",   perf_busy_cyc_out,          32'(m_busy));
        chk("perf_bubble", 32'(perf_bubble_cyc_out),   32'(m_bub));
`endif
    endtask

    task automatic model_advance();
        bit wr, fr, whs, fhs;
        wr  = m_wr();
        fr  = m_fr();
        whs = wr && w_valid_in;
        fhs = fr && f_valid_in;
        if (cyc < HIST) begin
            push_v[cyc] = fhs;
            push_d[cyc] = f_data_in;
        end
        if (m_act) m_busy++;
        if (fr && !fhs) m_bub++;
        m_ctrl = wr;
        if (whs) begin
            m_w = w_data_in;
            m_beats++;
            if (m_beats == COL && m_nv == 0) m_done_cyc = cyc + LAT + 1;
        end
        if (fhs) begin
            m_vecs++;
            if (m_vecs == m_nv) m_done_cyc = cyc + LAT + 1;
        end
        if (m_act && cyc == m_done_cyc) begin
            m_act = 1'b0;
            m_done_cyc = -1;
        end else if (!m_act && start_in) begin
            m_act = 1'b1;
            m_nv = int'(num_vecs_in);
            m_beats = 0;
            m_vecs = 0;
            m_done_cyc = -1;
            m_busy = 0;
            m_bub = 0;
        end
    endtask

    task automatic model_reset();
        m_act = 1'b0;
        m_ctrl = 1'b0;
        m_w = '0;
        m_done_cyc = -1;
        m_busy = 0;
        m_bub = 0;
        valid_from = cyc + 1;
    endtask

    // One clock: drive at posedge+1, check at negedge, then update the model.
    task automatic step(input bit st, input logic [VEC_W-1:0] nv, input bit wv, input bit fv,
                        input logic [DW-1:0] fd, input bit do_rst);
        start_in    = st;
        num_vecs_in = nv;
        w_valid_in  = wv;
        w_data_in   = DW'($urandom);
        f_valid_in  = fv;
        f_data_in   = fd;
        @(negedge clk_in);
        check_outputs();
        if (do_rst) begin
            rst_in = 1'b1;
            #1;
            rst_in = 1'b0;
            model_reset();
        end else begin
            model_advance();
        end
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    task automatic run_tile(input int nv, input int wprob, input int fprob,
                            input bit use_fpat, input logic [7:0] fpat,
                            input bit use_wpat, input logic [7:0] wpat,
                            input bit start_busy, input int rst_at, input bit fixed);
        int k_f;
        int k_w;
        int guard;
        bit wv;
        bit fv;
        logic [DW-1:0] fd;
        k_f = 0;
        k_w = 0;
        guard = 0;
        step(1'b1, VEC_W'(nv), 1'b0, 1'b0, '0, 1'b0);
        while (m_act && guard < 400) begin
            guard++;
            wv = ($urandom_range(99) < wprob);
            fv = ($urandom_range(99) < fprob);
            if (use_wpat && m_wr()) begin
                wv = (k_w < 8) ? wpat[k_w] : 1'b1;
                k_w++;
            end
            if (use_fpat && m_fr()) begin
                fv = (k_f < 8) ? fpat[k_f] : 1'b1;
                k_f++;
            end
            fd = (fixed && m_vecs == 0) ? 24'h030201 : DW'($urandom);
            if (rst_at > 0 && m_vecs == rst_at) begin
                step(1'b0, VEC_W'(nv), wv, fv, fd, 1'b1);
                break;
            end
            step(start_busy, VEC_W'($urandom), wv, fv, fd, 1'b0);
        end
        if (guard >= 400) begin
            total++;
            bad++;
            $error("FAIL tile_budget cycle=%0d got=busy expected=idle", cyc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0; bad = 0; cyc = 0; valid_from = 0;
        m_act = 1'b0; m_nv = 0; m_beats = 0; m_vecs = 0; m_done_cyc = -1;
        m_busy = 0; m_bub = 0; m_ctrl = 1'b0; m_w = '0;
        rst_in = 1'b1; start_in = 1'b0; num_vecs_in = '0;
        w_valid_in = 1'b0; w_data_in = '0; f_valid_in = 1'b0; f_data_in = '0;
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;

        repeat (2) step(1'b0, '0, 1'b1, 1'b1, '0, 1'b0);
        run_tile(4, 100, 100, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 0, 1'b1);
        repeat (2) step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        run_tile(4, 100, 100, 1'b1, 8'h2D, 1'b0, 8'h00, 1'b0, 0, 1'b0);
        run_tile(3, 100, 100, 1'b0, 8'h00, 1'b1, 8'h19, 1'b0, 0, 1'b0);
        run_tile(0, 100, 100, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        run_tile(5, 100, 100, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 2, 1'b0);
        repeat (LAT + 2) step(1'b0, '0, 1'b1, 1'b1, DW'($urandom), 1'b0);
        run_tile(2, 100, 100, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 0, 1'b0);
        run_tile(1, 100, 100, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 0, 1'b0);
        for (int t = 0; t < 12; t++) begin
            run_tile(int'($urandom_range(5)), int'($urandom_range(100, 30)),
                     int'($urandom_range(100, 30)), 1'b0, 8'h00, 1'b0, 8'h00,
                     1'($urandom_range(1)), 0, 1'b0);
        end
        repeat (2) step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
